// File: rtl/serial_subtractor_if.sv
// Start/busy/done bundle for serial_subtractor; master drives requests, slave returns results.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    // Handshake: start is sampled on a rising edge only while busy=0; a/b/bin are
    // captured on that edge. done pulses for one cycle when diff/bout (and ovf) change,
    // and those outputs then hold until the next completion or reset.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [1:0]       state_dbg;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, state_dbg
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, state_dbg
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             d_bit;
    logic             br_nxt;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_r;
`endif

    always_comb begin
        d_bit  = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            part   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_nxt;
                    part <= {d_bit, part[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // The final bit lands at the MSB, so publish the assembled word directly.
                        diff_r <= {d_bit, part[WIDTH-1:1]};
                        bout_r <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        br     <= bus.bin;
                        part   <= '0;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
`endif
                        state  <= RUN;
                        busy_r <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.state_dbg = state;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf       = ovf_r;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor against an arithmetic reference model.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  localparam int WIDTH = 8;
  localparam int EW = WIDTH + 2;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   accepted;
  int   done_cnt;
  logic [EW-1:0] exp_q[$];

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  // reference model: {ovf, bout, diff}
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic bin);
    int unsigned ua, ub;
    int sa, sb, sr;
    logic [WIDTH-1:0] d;
    logic bo, ov;
    ua = a;
    ub = b;
    d  = WIDTH'(ua - ub - bin);
    bo = (ua < ub + bin);
    sa = $signed(a);
    sb = $signed(b);
    sr = sa - sb - int'(bin);
    ov = (sr > (2 ** (WIDTH - 1)) - 1) || (sr < -(2 ** (WIDTH - 1)));
    return {ov, bo, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: call at a negedge; returns at the negedge after the accepting edge
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, bin));
    accepted++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom);
    bus.b = WIDTH'($urandom);
    bus.bin = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int elapsed);
    int n;
    bit seen;
    logic [EW-1:0] e;
    n = elapsed;
    seen = 1'b0;
    while (!seen && n < WIDTH + 4) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (seen) begin
      chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
      chk({tag, "_diff"}, 32'(bus.diff), 32'(e[WIDTH-1:0]));
      chk({tag, "_bout"}, 32'(bus.bout), 32'(e[WIDTH]));
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(e[WIDTH+1]));
`endif
    end
  endtask

  initial begin
    int gap;
    tests_run = 0;
    tests_failed = 0;
    accepted = 0;
    done_cnt = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_diff", 32'(bus.diff), 32'd0);
    chk("reset_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic op with an ignored mid-run start, then a back-to-back op from DONE
    launch(8'h5A, 8'h23, 1'b0);
    chk("t1_busy_run", 32'(bus.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'h99;
    bus.b = 8'h11;
    bus.bin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t3_busy_ignored", 32'(bus.busy), 32'd1);
    chk("t3_diff_hidden", 32'(bus.diff), 32'd0);
    wait_done("t1", 3);
    chk("t1_diff_const", 32'(bus.diff), 32'h37);
    launch(8'h99, 8'h11, 1'b0);
    chk("t3_b2b_busy", 32'(bus.busy), 32'd1);
    chk("t3_b2b_done_low", 32'(bus.done), 32'd0);
    chk("t3_hold_diff", 32'(bus.diff), 32'h37);
    wait_done("t3b2b", 0);
    chk("t3_diff_const", 32'(bus.diff), 32'h88);
    @(negedge clk);
    chk("t3_done_pulse_1cyc", 32'(bus.done), 32'd0);

    // borrow and wrap-around
    launch(8'h10, 8'h20, 1'b0);
    wait_done("t2_under", 0);
    chk("t2_under_diff", 32'(bus.diff), 32'hF0);
    @(negedge clk);
    launch(8'h00, 8'h00, 1'b1);
    wait_done("t2_wrap", 0);
    chk("t2_wrap_diff", 32'(bus.diff), 32'hFF);
    chk("t2_wrap_bout", 32'(bus.bout), 32'd1);
    @(negedge clk);

    // reset mid-run at count=4 aborts without a done pulse
    launch(8'h33, 8'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(bus.busy), 32'd0);
    chk("t4_rst_done", 32'(bus.done), 32'd0);
    chk("t4_rst_diff", 32'(bus.diff), 32'd0);
    chk("t4_rst_bout", 32'(bus.bout), 32'd0);
    void'(exp_q.pop_back());
    accepted--;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WIDTH + 2) @(negedge clk);
    chk("t4_no_done_cnt", 32'(done_cnt), 32'(accepted));
    launch(8'hFF, 8'h01, 1'b0);
    wait_done("t4_after", 0);
    chk("t4_after_diff", 32'(bus.diff), 32'hFE);
    @(negedge clk);

`ifdef SERIAL_SUB_OVF_EN
    launch(8'h7F, 8'hFF, 1'b0);
    wait_done("t5a", 0);
    chk("t5a_ovf_const", 32'(bus.ovf), 32'd1);
    launch(8'h80, 8'h01, 1'b0);
    wait_done("t5b", 0);
    chk("t5b_ovf_const", 32'(bus.ovf), 32'd1);
    launch(8'h05, 8'h03, 1'b0);
    wait_done("t5c", 0);
    chk("t5c_ovf_const", 32'(bus.ovf), 32'd0);
    @(negedge clk);
`endif

    // random sweep with random start gaps (gap 0 = start held in DONE)
    for (int i = 0; i < 500; i++) begin
      launch(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_done("rnd", 0);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        @(negedge clk);
        if (bus.done === 1'b1) chk("rnd_done_width", 32'(bus.done), 32'd0);
        repeat (gap - 1) @(negedge clk);
      end
    end
    repeat (2) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(accepted));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
